// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its busy-bit scoreboard.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 16;

  // busy_cnt must be able to hold DEPTH itself, hence DEPTH+1 values.
  function automatic int busy_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int sel_lsb(input int port, input int aw);
    return port * aw;
  endfunction

  function automatic int data_lsb(input int port, input int data_w);
    return port * data_w;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: per-register busy vector, allocation acceptance and busy count.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 0,
  parameter int AW       = $clog2(DEPTH),
  parameter int CNT_W    = busy_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_sel,
  input  logic             alloc_en,
  input  logic [AW-1:0]    alloc_sel,
  output logic             alloc_ack,
  output logic [DEPTH-1:0] busy,
  output logic [CNT_W-1:0] busy_cnt
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_eff, alloc_eff, cnt_inc, cnt_dec;

  always_comb begin
    wr_eff    = wr_en && !((ZERO_REG != 0) && (wr_sel == '0));
    // A same-cycle write-back frees the register, so a new producer may claim it.
    alloc_ack = alloc_en && (!busy_q[alloc_sel] || (wr_en && (wr_sel == alloc_sel)));
    alloc_eff = alloc_ack && !((ZERO_REG != 0) && (alloc_sel == '0));
    cnt_inc   = alloc_eff && !busy_q[alloc_sel];
    cnt_dec   = wr_eff && busy_q[wr_sel] && !(alloc_eff && (alloc_sel == wr_sel));

    busy_d = busy_q;
    if (wr_eff)    busy_d[wr_sel]    = 1'b0;
    if (alloc_eff) busy_d[alloc_sel] = 1'b1;

    cnt_d = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-to-read bypass and an integrated busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 0,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_sel,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [NUM_READ*AW-1:0]       rd_sel,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         alloc_en,
  input  logic [AW-1:0]                alloc_sel,
  output logic                         alloc_ack,
  output logic [busy_cnt_w(DEPTH)-1:0] busy_cnt
);

  localparam int CNT_W = busy_cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic              wr_take;

  assign wr_take = wr_en && !((ZERO_REG != 0) && (wr_sel == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_take) begin
      mem_q[wr_sel] <= wr_data;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .alloc_en  (alloc_en),
    .alloc_sel (alloc_sel),
    .alloc_ack (alloc_ack),
    .busy      (busy_vec),
    .busy_cnt  (busy_cnt)
  );

  // Each port sees the write-back value and a cleared busy bit in the cycle it is written.
  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [AW-1:0] sel;
    logic          bypass;
    logic          is_zero;

    assign sel     = rd_sel[sel_lsb(gi, AW) +: AW];
    assign bypass  = wr_en && (wr_sel == sel);
    assign is_zero = (ZERO_REG != 0) && (sel == '0);

    assign rd_data[data_lsb(gi, DATA_W) +: DATA_W] =
        is_zero ? '0 : (bypass ? wr_data : mem_q[sel]);
    assign rd_busy[gi] = !is_zero && !bypass && busy_vec[sel];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against a behavioural array model.
module tb_regfile_sb;

  logic        clk;
  logic        reset;

  logic        wr_en, alloc_en, alloc_ack;
  logic [3:0]  wr_sel, alloc_sel;
  logic [31:0] wr_data;
  logic [7:0]  rd_sel;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [4:0]  busy_cnt;

  logic        z_wr_en, z_alloc_en, z_alloc_ack;
  logic [3:0]  z_wr_sel, z_alloc_sel;
  logic [31:0] z_wr_data;
  logic [7:0]  z_rd_sel;
  logic [63:0] z_rd_data;
  logic [1:0]  z_rd_busy;
  logic [4:0]  z_busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  logic [31:0] m_regs [16];
  bit          m_busy [16];

  regfile_sb #(.DATA_W(32), .DEPTH(16), .NUM_READ(2), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
    .alloc_en(alloc_en), .alloc_sel(alloc_sel), .alloc_ack(alloc_ack),
    .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DATA_W(32), .DEPTH(16), .NUM_READ(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset),
    .wr_en(z_wr_en), .wr_sel(z_wr_sel), .wr_data(z_wr_data),
    .rd_sel(z_rd_sel), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
    .alloc_en(z_alloc_en), .alloc_sel(z_alloc_sel), .alloc_ack(z_alloc_ack),
    .busy_cnt(z_busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 16; i++) c += m_busy[i] ? 1 : 0;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One clocked transaction on the main instance; comb outputs checked before the edge,
  // busy_cnt checked just after it.
  task automatic step(input bit we, input int ws, input logic [31:0] wd,
                      input bit ae, input int as, input int r0, input int r1);
    logic [31:0] exp_d;
    bit          exp_b;
    bit          ack;
    int          s;
    wr_en = we; wr_sel = ws[3:0]; wr_data = wd;
    alloc_en = ae; alloc_sel = as[3:0];
    rd_sel = {r1[3:0], r0[3:0]};
    #1;
    for (int p = 0; p < 2; p++) begin
      s = (p == 0) ? r0 : r1;
      if (we && ws == s) begin
        exp_d = wd;
        exp_b = 1'b0;
      end else begin
        exp_d = m_regs[s];
        exp_b = m_busy[s];
      end
      check($sformatf("rd_data%0d", p), 64'(rd_data[p*32 +: 32]), 64'(exp_d));
      check($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(exp_b));
    end
    ack = ae && (!m_busy[as] || (we && ws == as));
    check("alloc_ack", 64'(alloc_ack), 64'(ack));
    $display("txn %0d: we=%0d ws=%0d wd=%08h ae=%0d as=%0d rd=%0d/%0d ack=%0d",
             n_txn, we, ws, wd, ae, as, r0, r1, alloc_ack);
    n_txn++;
    @(posedge clk);
    if (we) begin
      m_regs[ws] = wd;
      m_busy[ws] = 1'b0;
    end
    if (ack) m_busy[as] = 1'b1;
    #1;
    check("busy_cnt", 64'(busy_cnt), 64'(model_cnt()));
  endtask

  initial begin
    int ws, as, r0, r1;
    reset = 1'b1;
    wr_en = 0; wr_sel = 0; wr_data = 0; alloc_en = 0; alloc_sel = 0; rd_sel = 0;
    z_wr_en = 0; z_wr_sel = 0; z_wr_data = 0; z_alloc_en = 0; z_alloc_sel = 0; z_rd_sel = 0;
    model_clear();
    #1;
    check("rst_rd_data", rd_data, 64'h0);
    check("rst_rd_busy", 64'(rd_busy), 64'h0);
    check("rst_ack", 64'(alloc_ack), 64'h0);
    check("rst_cnt", 64'(busy_cnt), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 16; i++) step(0, 0, 32'h0, 0, 0, i, 15 - i);

    // bypass then stored value
    step(1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
    step(0, 0, 32'h0, 0, 0, 5, 1);
    check("bypass_hold", 64'(rd_data[31:0]), 64'hDEADBEEF);

    // scoreboard lifecycle on r3
    step(0, 0, 32'h0, 1, 3, 3, 0);
    check("lc_cnt1", 64'(busy_cnt), 64'd1);
    step(0, 0, 32'h0, 1, 3, 3, 0);
    step(1, 3, 32'h12, 0, 0, 3, 0);
    check("lc_cnt0", 64'(busy_cnt), 64'd0);

    // simultaneous alloc + write-back
    step(0, 0, 32'h0, 1, 7, 7, 0);
    step(1, 7, 32'h55, 1, 7, 7, 0);
    step(0, 0, 32'h0, 1, 9, 7, 9);
    step(1, 9, 32'hAA, 1, 2, 9, 2);
    check("sim_cnt", 64'(busy_cnt), 64'd2);
    step(0, 0, 32'h0, 0, 0, 2, 9);

    for (int n = 0; n < 300; n++) begin
      ws = $urandom_range(0, 15);
      as = $urandom_range(0, 15);
      r0 = $urandom_range(0, 15);
      r1 = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        as = ws;
        r0 = ws;
      end
      step(bit'($urandom_range(0, 1)), ws, $urandom, bit'($urandom_range(0, 2) != 0), as, r0, r1);
    end

    // fill all registers, then async reset between edges
    reset = 1'b1;
    #2 reset = 1'b0;
    model_clear();
    for (int i = 0; i < 16; i++) step(0, 0, 32'h0, 1, i, i, 0);
    check("fill_cnt", 64'(busy_cnt), 64'd16);
    wr_en = 0; alloc_en = 0; rd_sel = {4'd9, 4'd3};
    #2 reset = 1'b1;
    #2;
    model_clear();
    check("arst_cnt", 64'(busy_cnt), 64'd0);
    check("arst_busy", 64'(rd_busy), 64'd0);
    check("arst_data", rd_data, 64'h0);
    #2 reset = 1'b0;
    step(0, 0, 32'h0, 1, 4, 4, 9);
    step(0, 0, 32'h0, 0, 0, 4, 3);

    // hardwired-zero instance
    @(negedge clk);
    z_wr_en = 1; z_wr_sel = 0; z_wr_data = 32'hFFFFFFFF;
    z_alloc_en = 1; z_alloc_sel = 0; z_rd_sel = {4'd0, 4'd0};
    #1;
    check("z_rd_data", z_rd_data, 64'h0);
    check("z_rd_busy", 64'(z_rd_busy), 64'h0);
    check("z_ack", 64'(z_alloc_ack), 64'd1);
    $display("txn %0d: zero-reg write+alloc r0", n_txn); n_txn++;
    @(posedge clk); #1;
    check("z_cnt0", 64'(z_busy_cnt), 64'd0);
    z_wr_en = 1; z_wr_sel = 4; z_wr_data = 32'hAB; z_alloc_en = 1; z_alloc_sel = 4;
    z_rd_sel = {4'd4, 4'd0};
    #1;
    check("z_bypass", 64'(z_rd_data[63:32]), 64'hAB);
    check("z_r0_bypass", 64'(z_rd_data[31:0]), 64'h0);
    $display("txn %0d: zero-reg write+alloc r4", n_txn); n_txn++;
    @(posedge clk); #1;
    z_wr_en = 0; z_alloc_en = 0;
    #1;
    check("z_r4_hold", 64'(z_rd_data[63:32]), 64'hAB);
    check("z_r4_busy", 64'(z_rd_busy), 64'b10);
    check("z_cnt1", 64'(z_busy_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read-port register file with an integrated busy-bit scoreboard, for the pipelined core's decode/write-back stages.
- One synchronous write port; NUM_READ combinational read ports with same-cycle write-to-read bypass.
- Per-register busy bit: set when decode allocates a destination, cleared on write-back.
- Decode uses the busy bits for RAW/WAW stall decisions.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 16, number of registers; power of two, at least 2
- NUM_READ, 2, number of read ports, 1..4
- ZERO_REG, 0, 1 = register 0 is hardwired to zero (writes and allocations to it have no effect)
- AW, $clog2(DEPTH), derived register-select width; not to be overridden

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write-back enable
- wr_sel  in  AW  write-back register index
- wr_data  in  DATA_W  write-back data
- rd_sel  in  NUM_READ*AW  read indices; port i uses bits [i*AW +: AW]
- rd_data  out  NUM_READ*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_READ  port i's register is busy after this cycle's write-back is taken into account
- alloc_en  in  1  request to mark a destination register busy
- alloc_sel  in  AW  register index to allocate
- alloc_ack  out  1  allocation accepted this cycle (combinational)
- busy_cnt  out  $clog2(DEPTH+1)  number of registers currently busy

Behaviour:
- Reset (asynchronous, immediate):
  - all registers cleared to 0
  - all busy bits cleared
  - busy_cnt = 0
  - with inputs idle, rd_data = 0, rd_busy = 0 and alloc_ack = 0
- Reset asserted mid-operation discards every pending allocation; no write is performed on an edge where reset is high.
- Write: on a rising edge with wr_en=1, reg[wr_sel] <= wr_data and busy[wr_sel] <= 0.
  - A write to a non-busy register is legal and leaves busy at 0.
  - ZERO_REG=1 and wr_sel=0: the write is ignored.
- Read (combinational, zero latency):
  - rd_data[i] = wr_data if wr_en and wr_sel == rd_sel[i]; otherwise reg[rd_sel[i]].
  - ZERO_REG=1 and rd_sel[i]=0: rd_data[i] = 0 and rd_busy[i] = 0, regardless of bypass.
  - rd_busy[i] = busy[rd_sel[i]], except 0 when the bypass is active for that port.
  - Multiple ports may select the same register; each gets identical results.
- Allocate:
  - alloc_ack = alloc_en and (busy[alloc_sel] = 0, or wr_en and wr_sel == alloc_sel).
  - An allocation to a busy register with no same-cycle write-back is rejected: alloc_ack = 0 and no state changes (WAW stall).
  - On an edge with alloc_ack=1, busy[alloc_sel] <= 1.
  - Allocation and write-back to the same register in the same cycle: the write occurs and busy ends at 1 (the new producer wins).
  - ZERO_REG=1 and alloc_sel=0: alloc_ack = alloc_en, busy is never set.
- busy_cnt: registered; next value = current + (busy bit set by allocation) - (busy bit cleared by write).
  - Same-register alloc+write: net 0.
  - Different registers: +1 and -1 combine, net 0.
  - Never exceeds DEPTH (DEPTH-1 with ZERO_REG=1); never underflows, because writes to non-busy registers do not decrement.
- Width rule: all selects are exactly AW bits, so no out-of-range index is possible.

Decomposition:
- Shared package regfile_pkg:
  - default DATA_W/DEPTH
  - a localparam function for the busy_cnt width
  - read-port slicing helper functions
- One natural sub-module, rf_scoreboard: holds the busy vector, alloc_ack logic and busy_cnt.
- regfile_sb instantiates rf_scoreboard and holds the storage array, bypass and read muxes.

Test Plan:
- Reset then read: assert reset, release; read r0..r15 on both ports -> every rd_data = 0, rd_busy = 0, busy_cnt = 0.
- Write-then-read and bypass: write r5 = 0xDEADBEEF with rd_sel0 = 5 in the same cycle -> rd_data0 = 0xDEADBEEF combinationally; next cycle, with wr_en=0, rd_data0 still = 0xDEADBEEF.
- Scoreboard lifecycle: alloc r3 -> alloc_ack = 1, next cycle rd_busy = 1 on a port reading r3, busy_cnt = 1; second alloc r3 -> alloc_ack = 0; write-back r3 = 0x12 -> same cycle rd_busy = 0 and rd_data = 0x12, next cycle busy_cnt = 0.
- Simultaneous events:
  - r7 busy; alloc r7 plus write r7 = 0x55 in one cycle -> alloc_ack = 1, reg = 0x55, busy stays 1, busy_cnt unchanged.
  - alloc r2 plus write-back of busy r9 in one cycle -> busy_cnt unchanged, r2 busy, r9 free.
- ZERO_REG=1 build: write r0 = 0xFFFFFFFF, alloc r0 -> rd_data = 0, rd_busy = 0, alloc_ack = 1, busy_cnt = 0.
- Fill and async reset: allocate all 16 registers -> busy_cnt = 16; assert reset between clock edges -> busy_cnt = 0 and all rd_busy = 0 before the next edge.
